pipeline_ctrl: RTL
==================

// Module: pipeline_ctrl
// PURPOSE
//  Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Detects load-use hazards, resolves taken branches and stalls on multi-cycle
//  data-memory accesses through a req/ack handshake.
//  Drives per-stage write-enable and flush lines; counts stall cycles; flags memory timeouts.
// PARAMETERS
//  INDEX      5   register-index width
//  TIMEOUT    64  max MEM_WAIT cycles before ERROR (>=2)
//  CNT_W      16  stall performance-counter width
// PORTS
//  clk_in            in   1      clock, rising edge
//  rst_in            in   1      reset, synchronous, active-high
//  ifid_rs1_in       in   INDEX  rs1 of instruction in ID
//  ifid_rs2_in       in   INDEX  rs2 of instruction in ID
//  idex_rd_in        in   INDEX  rd of instruction in EX
//  idex_mem_read_in  in   1      EX instruction is a load
//  exmem_mem_in      in   1      MEM instruction is a load/store
//  exmem_br_taken_in in   1      MEM branch resolved taken (branch & zero)
//  dmem_ack_in       in   1      data memory completes access this cycle
//  pc_write_out      out  1      PC update enable
//  pc_sel_out        out  1      1 = load PC from EX/MEM pc_branch
//  ifid_write_out    out  1      IF/ID enable
//  idex_write_out    out  1      ID/EX enable
//  exmem_write_out   out  1      EX/MEM enable
//  ifid_flush_out    out  1      IF/ID flush
//  idex_flush_out    out  1      ID/EX flush (bubble)
//  exmem_flush_out   out  1      EX/MEM flush
//  memwb_flush_out   out  1      MEM/WB flush (bubble into WB)
//  dmem_req_out      out  1      data memory request
//  stall_cnt_out     out  CNT_W  total stall cycles, saturating
//  err_out           out  1      sticky memory-timeout error
// BEHAVIOUR
//  - Outputs combinational from state + inputs; state, wait counter, stall_cnt, err registered.
//  - rst_in=1: next edge -> RUN, wait_cnt=0, stall_cnt=0, err=0. While rst_in=1 outputs forced:
//    all *_write_out=0, all *_flush_out=1, pc_sel_out=0, dmem_req_out=0, err_out=0.
//    Reset mid-MEM_WAIT drops dmem_req_out in the same cycle.
//  - Default (RUN, no event): all writes 1, all flushes 0, pc_sel 0, dmem_req 0.
//  - States RUN, MEM_WAIT, ERROR. Priority in RUN: memory > branch > load-use.
//  - RUN, exmem_mem_in=1: dmem_req_out=1.
//    ack=1: no stall (zero-wait access), stay RUN.
//    ack=0: pc/ifid/idex/exmem writes 0, memwb_flush 1, wait_cnt<=1, -> MEM_WAIT.
//  - MEM_WAIT: dmem_req_out=1.
//    ack=0: same hold as above; wait_cnt++. When wait_cnt==TIMEOUT-1 with ack=0 -> ERROR.
//    ack=1: default outputs (pipeline advances this cycle), wait_cnt<=0, -> RUN.
//    Branch/load-use inputs are ignored in MEM_WAIT; they re-evaluate in RUN.
//  - Branch (RUN, exmem_br_taken_in=1, exmem_mem_in=0): pc_sel 1, pc_write 1;
//    ifid/idex/exmem flush 1. Penalty 3 cycles, no state change.
//  - Load-use (RUN, no branch/mem): idex_mem_read_in && idex_rd_in!=0 &&
//    (idex_rd_in==ifid_rs1_in || idex_rd_in==ifid_rs2_in) -> pc_write 0, ifid_write 0,
//    idex_flush 1. Exactly 1 bubble per hazard; rd==0 never stalls.
//  - exmem_mem_in && exmem_br_taken_in together is illegal (assertion); memory wins.
//  - ERROR: all writes 0, all flushes 0, dmem_req 0, err_out 1; left only by rst_in.
//  - stall_cnt_out +1 on every cycle with pc_write_out=0 outside reset/ERROR;
//    saturates at all-ones with no wrap.
//  - wait_cnt width $clog2(TIMEOUT)+1. All compares unsigned.
// STRUCTURE
//  - riscv_types gains: typedef enum logic [1:0] {PC_RUN, PC_MEM_WAIT, PC_ERROR} pipe_state_t;
//    typedef struct packed pipe_ctrl_t {write/flush bits} shared with the pipeline registers.
//  - Sub-module hazard_detect (combinational load-use compare); FSM and counters stay top-level.
// TESTING
//  - Reset: rst 1 for 2 cycles mid-MEM_WAIT -> writes 0, flushes 1, req 0; after release
//    stall_cnt 0, err 0, default outputs.
//  - Load-use: idex_mem_read=1, rd=5, rs1=5 -> pc_write=ifid_write=0, idex_flush=1 for 1
//    cycle, stall_cnt=1. Same test with rd=0 -> no stall.
//  - Branch+load-use same cycle -> pc_sel=1, three flushes, pc_write=1, no stall counted.
//  - Mem wait: exmem_mem=1, ack after 3 cycles -> 3 hold cycles with memwb_flush=1,
//    advance on ack cycle, stall_cnt=3. With ack same cycle -> zero stall.
//  - Timeout: TIMEOUT=4, ack never -> ERROR after 4 hold cycles, err_out sticky, req 0;
//    rst clears it.
//  - Saturation: CNT_W=3, 10 load-use stalls -> stall_cnt_out=7.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM state encoding and the bundle of
// per-stage write/flush controls consumed by the pipeline registers.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_RUN      = 2'd0,
    PC_MEM_WAIT = 2'd1,
    PC_ERROR    = 2'd2
  } pipe_state_t;

  typedef struct packed {
    logic pc_write;
    logic pc_sel;
    logic ifid_write;
    logic idex_write;
    logic exmem_write;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
    logic dmem_req;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN = '{pc_write: 1'b1, pc_sel: 1'b0, ifid_write: 1'b1,
                                      idex_write: 1'b1, exmem_write: 1'b1, ifid_flush: 1'b0,
                                      idex_flush: 1'b0, exmem_flush: 1'b0, memwb_flush: 1'b0,
                                      dmem_req: 1'b0};

  localparam pipe_ctrl_t CTRL_RESET = '{pc_write: 1'b0, pc_sel: 1'b0, ifid_write: 1'b0,
                                        idex_write: 1'b0, exmem_write: 1'b0, ifid_flush: 1'b1,
                                        idex_flush: 1'b1, exmem_flush: 1'b1, memwb_flush: 1'b1,
                                        dmem_req: 1'b0};

  // Freeze everything up to MEM and push a bubble into WB while memory is busy.
  localparam pipe_ctrl_t CTRL_HOLD = '{pc_write: 1'b0, pc_sel: 1'b0, ifid_write: 1'b0,
                                       idex_write: 1'b0, exmem_write: 1'b0, ifid_flush: 1'b0,
                                       idex_flush: 1'b0, exmem_flush: 1'b0, memwb_flush: 1'b1,
                                       dmem_req: 1'b1};

  localparam pipe_ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use hazard compare between the load in EX and the
// source registers of the instruction in ID.
module hazard_detect #(
  parameter int unsigned INDEX = 5
) (
  input  logic             idex_mem_read,
  input  logic [INDEX-1:0] idex_rd,
  input  logic [INDEX-1:0] ifid_rs1,
  input  logic [INDEX-1:0] ifid_rs2,
  output logic             load_use
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = idex_mem_read && (idex_rd != '0) &&
                    ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: resolves memory stalls, taken branches and load-use hazards
// into per-stage write/flush controls; counts stall cycles and flags memory timeouts.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned INDEX   = 5,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [INDEX-1:0] ifid_rs1_in,
  input  logic [INDEX-1:0] ifid_rs2_in,
  input  logic [INDEX-1:0] idex_rd_in,
  input  logic             idex_mem_read_in,
  input  logic             exmem_mem_in,
  input  logic             exmem_br_taken_in,
  input  logic             dmem_ack_in,
  output logic             pc_write_out,
  output logic             pc_sel_out,
  output logic             ifid_write_out,
  output logic             idex_write_out,
  output logic             exmem_write_out,
  output logic             ifid_flush_out,
  output logic             idex_flush_out,
  output logic             exmem_flush_out,
  output logic             memwb_flush_out,
  output logic             dmem_req_out,
  output logic [CNT_W-1:0] stall_cnt_out,
  output logic             err_out
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  pipe_state_t       state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              err_q;
  logic              load_use;
  pipe_ctrl_t        ctrl;

  hazard_detect #(
    .INDEX(INDEX)
  ) u_hazard_detect (
    .idex_mem_read(idex_mem_read_in),
    .idex_rd      (idex_rd_in),
    .ifid_rs1     (ifid_rs1_in),
    .ifid_rs2     (ifid_rs2_in),
    .load_use     (load_use)
  );

  always_comb begin
    ctrl       = CTRL_RUN;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    if (rst_in) begin
      ctrl       = CTRL_RESET;
      state_d    = PC_RUN;
      wait_cnt_d = '0;
    end else begin
      unique case (state_q)
        PC_RUN: begin
          if (exmem_mem_in) begin
            ctrl.dmem_req = 1'b1;
            if (!dmem_ack_in) begin
              ctrl       = CTRL_HOLD;
              wait_cnt_d = WAIT_W'(1);
              state_d    = PC_MEM_WAIT;
            end
          end else if (exmem_br_taken_in) begin
            ctrl.pc_sel      = 1'b1;
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_flush  = 1'b1;
            ctrl.exmem_flush = 1'b1;
          end else if (load_use) begin
            ctrl.pc_write   = 1'b0;
            ctrl.ifid_write = 1'b0;
            ctrl.idex_flush = 1'b1;
          end
        end
        PC_MEM_WAIT: begin
          ctrl.dmem_req = 1'b1;
          if (dmem_ack_in) begin
            wait_cnt_d = '0;
            state_d    = PC_RUN;
          end else begin
            ctrl       = CTRL_HOLD;
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            if (wait_cnt_q == WAIT_LAST) state_d = PC_ERROR;
          end
        end
        PC_ERROR: ctrl = CTRL_IDLE;
        default:  state_d = PC_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= PC_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (state_d == PC_ERROR) err_q <= 1'b1;
      if (state_q != PC_ERROR && !ctrl.pc_write && stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      assert (!(exmem_mem_in && exmem_br_taken_in))
        else $error("memory access and taken branch asserted together in MEM");
    end
  end

  assign pc_write_out    = ctrl.pc_write;
  assign pc_sel_out      = ctrl.pc_sel;
  assign ifid_write_out  = ctrl.ifid_write;
  assign idex_write_out  = ctrl.idex_write;
  assign exmem_write_out = ctrl.exmem_write;
  assign ifid_flush_out  = ctrl.ifid_flush;
  assign idex_flush_out  = ctrl.idex_flush;
  assign exmem_flush_out = ctrl.exmem_flush;
  assign memwb_flush_out = ctrl.memwb_flush;
  assign dmem_req_out    = ctrl.dmem_req;
  assign stall_cnt_out   = stall_cnt_q;
  assign err_out         = err_q && !rst_in;

endmodule
